// File: rtl/bus_snoop_serializer.sv
// Bus snapshot serializer: captures CHANNELS x WIDTH bits on trig_in rising edges
// into a small FIFO and drains each entry as a framed word, one serial lane per channel.
module bus_snoop_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 3,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DIV       = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      trig_in,
   input  logic [CHANNELS*WIDTH-1:0] d_in,
   output logic                      sclk,
   output logic [CHANNELS-1:0]       sdata,
   output logic                      frame,
   output logic                      idle,
   output logic                      overflow,
   output logic [7:0]                dropped_count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PW  = AW + 1;
   localparam int unsigned BW  = $clog2(WIDTH);
   localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DBW = CHANNELS * WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t          state;
   logic            trig_prev;
   logic [PW-1:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [DBW-1:0]  mem [0:DEPTH-1];
   logic [DBW-1:0]  head;
   logic [DBW-1:0]  shreg;
   logic [BW-1:0]   bitcnt;
   logic [DW-1:0]   div_cnt;
   logic            cap, full, pop, accept, drop, tick, nxt_empty;

   assign cap       = trig_in & ~trig_prev;
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop       = (state == LOAD);
   // A pop in the same cycle frees the slot, so a capture into a full FIFO is still taken.
   assign accept    = cap & (~full | pop);
   assign drop      = cap & full & ~pop;
   assign tick      = (div_cnt == DW'(DIV - 1));
   assign wr_nxt    = accept ? wr_ptr + PW'(1) : wr_ptr;
   assign rd_nxt    = pop ? rd_ptr + PW'(1) : rd_ptr;
   assign nxt_empty = (wr_nxt == rd_nxt);
   assign head      = mem[rd_ptr[AW-1:0]];

   // Snapshot storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[AW-1:0]] <= d_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         trig_prev     <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         shreg         <= '0;
         bitcnt        <= '0;
         div_cnt       <= '0;
         sclk          <= 1'b0;
         sdata         <= '0;
         frame         <= 1'b0;
         idle          <= 1'b1;
         overflow      <= 1'b0;
         dropped_count <= 8'd0;
      end else begin
         trig_prev <= trig_in;
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         if (drop) begin
            overflow <= 1'b1;
            if (dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
         end
         idle <= nxt_empty & ((state == IDLE) | ((state == GAP) & tick));

         case (state)
            IDLE: begin
               div_cnt <= '0;
               if (!nxt_empty) state <= LOAD;
            end
            LOAD: begin
               shreg   <= head;
               for (int k = 0; k < CHANNELS; k++)
                  sdata[k] <= MSB_FIRST ? head[k*WIDTH + WIDTH - 1] : head[k*WIDTH];
               frame   <= 1'b1;
               sclk    <= 1'b0;
               bitcnt  <= '0;
               div_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               div_cnt <= tick ? '0 : div_cnt + DW'(1);
               if (tick) begin
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bitcnt == BW'(WIDTH - 1)) begin
                        frame <= 1'b0;
                        sdata <= '0;
                        state <= GAP;
                     end else begin
                        bitcnt <= bitcnt + BW'(1);
                        for (int k = 0; k < CHANNELS; k++) begin
                           if (MSB_FIRST) begin
                              shreg[k*WIDTH +: WIDTH] <= {shreg[k*WIDTH +: WIDTH-1], 1'b0};
                              sdata[k] <= shreg[k*WIDTH + WIDTH - 2];
                           end else begin
                              shreg[k*WIDTH +: WIDTH] <= {1'b0, shreg[k*WIDTH + 1 +: WIDTH-1]};
                              sdata[k] <= shreg[k*WIDTH + 1];
                           end
                        end
                     end
                  end
               end
            end
            GAP: begin
               div_cnt <= tick ? '0 : div_cnt + DW'(1);
               if (tick) state <= nxt_empty ? IDLE : LOAD;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_snoop_serializer.sv
// Self-checking bench for bus_snoop_serializer: directed scenarios plus random bursts,
// with serial words reassembled from the pins and compared against a snapshot queue.
module tb_bus_snoop_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        trig_in;
   logic [23:0] d_in;
   logic        sclk;
   logic [2:0]  sdata;
   logic        frame, idle, overflow;
   logic [7:0]  dropped_count;

   logic        trig_b;
   logic [3:0]  d_b;
   logic        sclk_b;
   logic [0:0]  sdata_b;
   logic        frame_b, idle_b, overflow_b;
   logic [7:0]  dropped_b;

   int checks = 0;
   int errors = 0;

   logic [23:0] exp_q[$];
   bit          const_mode = 1'b0;
   logic [23:0] const_word = 24'h0;

   bus_snoop_serializer dut (
      .clk(clk), .reset(reset), .trig_in(trig_in), .d_in(d_in),
      .sclk(sclk), .sdata(sdata), .frame(frame), .idle(idle),
      .overflow(overflow), .dropped_count(dropped_count)
   );

   bus_snoop_serializer #(.WIDTH(4), .CHANNELS(1), .DEPTH(4), .DIV(1), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .trig_in(trig_b), .d_in(d_b),
      .sclk(sclk_b), .sdata(sdata_b), .frame(frame_b), .idle(idle_b),
      .overflow(overflow_b), .dropped_count(dropped_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Pin-level monitor: rebuilds each word from sdata on sclk rises inside a frame.
   logic [23:0] rx_word, last_word;
   int          rx_bits = 0, frame_len = 0, frames_done = 0, frames_started = 0;
   bit          in_frame = 1'b0;
   logic        prev_sclk = 1'b0, prev_frame = 1'b0;
   logic [2:0]  prev_sdata = 3'b0;

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         in_frame = 1'b0;
         rx_bits  = 0;
      end else begin
         if (frame === 1'b1 && prev_frame === 1'b0) begin
            in_frame = 1'b1;
            rx_bits  = 0;
            frame_len = 0;
            rx_word  = 24'h0;
            frames_started++;
         end
         if (in_frame && frame === 1'b1) frame_len++;
         if (in_frame && frame === 1'b1 && sclk === 1'b1 && prev_sclk === 1'b0) begin
            check("sdata_stable_at_rise", 32'(sdata), 32'(prev_sdata));
            if (rx_bits < 8)
               for (int k = 0; k < 3; k++) rx_word[k*8 + 7 - rx_bits] = sdata[k];
            rx_bits++;
         end
         if (in_frame && frame === 1'b0 && prev_frame === 1'b1) begin
            logic [23:0] want;
            in_frame = 1'b0;
            frames_done++;
            last_word = rx_word;
            check("bits_per_frame", 32'(rx_bits), 32'd8);
            check("frame_len", 32'(frame_len), 32'd32);
            if (const_mode) begin
               want = const_word;
            end else begin
               check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
               want = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
            end
            check("word_data", 32'(rx_word), 32'(want));
         end
      end
      prev_sclk  = sclk;
      prev_frame = frame;
      prev_sdata = sdata;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse(input logic [23:0] d, input bit accepted);
      d_in    = d;
      trig_in = 1'b1;
      cyc(1);
      trig_in = 1'b0;
      if (accepted) exp_q.push_back(d);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (idle === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_within_budget", 32'(ok), 32'd1);
      cyc(1);
      check("all_words_seen", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0, fs0, n, len_b;
      bit found;
      logic [3:0] seq_b;
      logic prev_sclk_b;

      reset = 1'b1; trig_in = 1'b0; d_in = 24'h0; trig_b = 1'b0; d_b = 4'h0;
      cyc(3);
      @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_sdata", 32'(sdata), 32'd0);
      check("rst_frame", 32'(frame), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_dropped", 32'(dropped_count), 32'd0);
      check("rst_idle_b", 32'(idle_b), 32'd1);
      cyc(1);
      reset = 1'b0;
      cyc(2);

      // 1: single capture, two-clock latency to frame, known lane patterns
      pulse(24'hA5_3C_81, 1'b1);
      @(negedge clk);
      check("latency_frame_low", 32'(frame), 32'd0);
      @(negedge clk);
      check("latency_frame_high", 32'(frame), 32'd1);
      wait_idle(200);
      check("t1_lane0", 32'(last_word[7:0]), 32'h81);
      check("t1_lane2", 32'(last_word[23:16]), 32'hA5);

      // 2: level held high captures once
      fd0 = frames_done;
      d_in = 24'h12_34_56;
      exp_q.push_back(d_in);
      trig_in = 1'b1;
      cyc(10);
      trig_in = 1'b0;
      wait_idle(300);
      check("t2_one_frame", 32'(frames_done - fd0), 32'd1);
      check("t2_no_drop", 32'(dropped_count), 32'd0);

      // Random bursts spaced so the shifter plus FIFO never overflow
      for (int b = 0; b < 6; b++) begin
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            pulse(24'($urandom), 1'b1);
            cyc($urandom_range(1, 3));
         end
         wait_idle(400);
      end
      check("rand_no_drop", 32'(dropped_count), 32'd0);
      check("rand_no_overflow", 32'(overflow), 32'd0);

      // 3: six captures two clocks apart; one in the shifter, four queued, sixth dropped
      fd0 = frames_done;
      for (int i = 0; i < 6; i++) begin
         pulse(24'($urandom), i < 5);
         if (i < 5) cyc(1);
      end
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_dropped", 32'(dropped_count), 32'd1);
      wait_idle(400);
      check("t3_five_frames", 32'(frames_done - fd0), 32'd5);

      // 4: hammer triggers while the FIFO stays full
      const_word = 24'h5A_C3_0F;
      const_mode = 1'b1;
      d_in = const_word;
      for (int i = 0; i < 300; i++) begin
         trig_in = 1'b1;
         cyc(1);
         trig_in = 1'b0;
         cyc(1);
      end
      check("t4_saturated", 32'(dropped_count), 32'd255);
      check("t4_overflow", 32'(overflow), 32'd1);
      wait_idle(400);
      const_mode = 1'b0;
      cyc(20);
      check("t4_overflow_sticky", 32'(overflow), 32'd1);

      // 5: reset in the middle of a frame discards everything
      pulse(24'hC0_FF_EE, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         if (in_frame && rx_bits == 3) begin
            found = 1'b1;
            break;
         end
      end
      check("t5_reached_bit3", 32'(found), 32'd1);
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t5_sclk", 32'(sclk), 32'd0);
      check("t5_sdata", 32'(sdata), 32'd0);
      check("t5_frame", 32'(frame), 32'd0);
      check("t5_idle", 32'(idle), 32'd1);
      cyc(1);
      reset = 1'b0;
      fs0 = frames_started;
      cyc(100);
      check("t5_no_frames", 32'(frames_started - fs0), 32'd0);
      check("t5_idle_after", 32'(idle), 32'd1);
      check("t5_overflow_clr", 32'(overflow), 32'd0);
      check("t5_dropped_clr", 32'(dropped_count), 32'd0);

      // 6: LSB-first, DIV=1, one 4-bit lane
      d_b = 4'b0011;
      trig_b = 1'b1;
      cyc(1);
      trig_b = 1'b0;
      seq_b = 4'h0;
      len_b = 0;
      n = 0;
      prev_sclk_b = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_b === 1'b1) begin
            len_b++;
            if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
               if (n < 4) seq_b[n] = sdata_b[0];
               n++;
            end
         end
         prev_sclk_b = sclk_b;
      end
      check("t6_bit_count", 32'(n), 32'd4);
      check("t6_bits", 32'(seq_b), 32'(4'b0011));
      check("t6_frame_len", 32'(len_b), 32'd8);
      check("t6_idle", 32'(idle_b), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
